// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU command encodings, wait-FSM states and operand-need helpers (ALU_MUL_EN)
package alu_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN,
    A_INC_A, A_DEC_A, A_INC_B, A_DEC_B,
    A_CMP, A_MUL_INC, A_MUL_SHL
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR,
    L_NOT_A, L_NOT_B,
    L_SHR1_A, L_SHL1_A, L_SHR1_B, L_SHL1_B,
    L_ROL, L_ROR
  } logic_cmd_e;

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} op_state_e;

  // Invalid commands need neither operand; callers treat that as an error.
  function automatic logic needs_a(input logic mode, input logic [3:0] cmd);
    logic r;
    r = 1'b0;
    if (mode) begin
      case (cmd)
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_A, A_DEC_A, A_CMP: r = 1'b1;
`ifdef ALU_MUL_EN
        A_MUL_INC, A_MUL_SHL: r = 1'b1;
`endif
        default: r = 1'b0;
      endcase
    end else begin
      case (cmd)
        L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR,
        L_NOT_A, L_SHR1_A, L_SHL1_A, L_ROL, L_ROR: r = 1'b1;
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic needs_b(input logic mode, input logic [3:0] cmd);
    logic r;
    r = 1'b0;
    if (mode) begin
      case (cmd)
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_B, A_DEC_B, A_CMP: r = 1'b1;
`ifdef ALU_MUL_EN
        A_MUL_INC, A_MUL_SHL: r = 1'b1;
`endif
        default: r = 1'b0;
      endcase
    end else begin
      case (cmd)
        L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR,
        L_NOT_B, L_SHR1_B, L_SHL1_B, L_ROL, L_ROR: r = 1'b1;
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_operand_sync.sv
// rtl/alu_operand_sync.sv - assembles operands arriving in separate cycles; wait FSM with timeout
module alu_operand_sync
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             mode,
  input  logic [3:0]       cmd,
  input  logic [1:0]       inp_valid,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic             op_valid,
  output logic             op_reject,
  output logic             op_timeout,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [3:0]       op_cmd,
  output logic             op_mode,
  output logic             op_cin
);

  localparam int TW = $clog2(TIMEOUT + 1);

  op_state_e        state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [3:0]       lat_cmd;
  logic             lat_mode, lat_cin;
  logic             ld_a, ld_b, ld_ctl;
  logic             na, nb;

  assign na = needs_a(mode, cmd);
  assign nb = needs_b(mode, cmd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_cmd  <= '0;
      lat_mode <= 1'b0;
      lat_cin  <= 1'b0;
    end else if (ce) begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (ld_a) lat_a <= opa;
      if (ld_b) lat_b <= opb;
      if (ld_ctl) begin
        lat_cmd  <= cmd;
        lat_mode <= mode;
        lat_cin  <= cin;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    op_valid   = 1'b0;
    op_reject  = 1'b0;
    op_timeout = 1'b0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_ctl     = 1'b0;
    op_a       = opa;
    op_b       = opb;
    op_cmd     = cmd;
    op_mode    = mode;
    op_cin     = cin;
    if (state != IDLE) begin
      op_cmd  = lat_cmd;
      op_mode = lat_mode;
      op_cin  = lat_cin;
    end
    if (state == WAIT_B) op_a = lat_a;
    if (state == WAIT_A) op_b = lat_b;
    if (ce) begin
      case (state)
        IDLE: begin
          timer_nxt = '0;
          if (inp_valid == 2'b00) begin
            op_reject = 1'b1;
          end else if (na && nb) begin
            if (inp_valid == 2'b11) begin
              op_valid = 1'b1;
            end else if (inp_valid == 2'b01) begin
              ld_a      = 1'b1;
              ld_ctl    = 1'b1;
              state_nxt = WAIT_B;
            end else begin
              ld_b      = 1'b1;
              ld_ctl    = 1'b1;
              state_nxt = WAIT_A;
            end
          end else if ((na && inp_valid[0]) || (nb && inp_valid[1])) begin
            op_valid = 1'b1;
          end else begin
            op_reject = 1'b1;
          end
        end
        WAIT_A, WAIT_B: begin
          // Arrival is checked before the timer so the last waiting cycle still counts.
          if ((state == WAIT_B) ? inp_valid[1] : inp_valid[0]) begin
            op_valid  = 1'b1;
            state_nxt = IDLE;
            timer_nxt = '0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            op_timeout = 1'b1;
            state_nxt  = IDLE;
            timer_nxt  = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered ALU responder; ALU_MUL_EN builds the 2-stage multiply pipeline
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             mode,
  input  logic [3:0]       cmd,
  input  logic [1:0]       inp_valid,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic [WIDTH:0]   res,
  output logic             cout,
  output logic             oflow,
  output logic             err,
  output logic             g,
  output logic             l,
  output logic             e
);

  localparam int SH = $clog2(WIDTH);

  logic             op_valid, op_reject, op_timeout, op_mode, op_cin;
  logic [WIDTH-1:0] a, b, lres;
  logic [3:0]       op_cmd;
  logic [WIDTH:0]   ax, bx, cx, one, c_res;
  logic [2*WIDTH-1:0] rot;
  logic [SH-1:0]    amt;
  logic             c_cout, c_oflow, c_err, c_g, c_l, c_e, c_mul;

  alu_operand_sync #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_sync (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cmd(cmd), .inp_valid(inp_valid),
    .opa(opa), .opb(opb), .cin(cin),
    .op_valid(op_valid), .op_reject(op_reject), .op_timeout(op_timeout),
    .op_a(a), .op_b(b), .op_cmd(op_cmd), .op_mode(op_mode), .op_cin(op_cin)
  );

  assign ax  = {1'b0, a};
  assign bx  = {1'b0, b};
  assign cx  = {{WIDTH{1'b0}}, op_cin};
  assign one = {{WIDTH{1'b0}}, 1'b1};
  assign amt = b[SH-1:0];

  always_comb begin
    c_res = '0; c_cout = 1'b0; c_oflow = 1'b0; c_err = 1'b0;
    c_g = 1'b0; c_l = 1'b0; c_e = 1'b0; c_mul = 1'b0;
    lres = '0; rot = '0;
    if (op_mode) begin
      case (op_cmd)
        A_ADD:     c_res = ax + bx;
        A_SUB:     begin c_res = ax - bx; c_oflow = ax < bx; end
        A_ADD_CIN: c_res = ax + bx + cx;
        A_SUB_CIN: begin c_res = ax - bx - cx; c_oflow = ax < (bx + cx); end
        A_INC_A:   c_res = ax + one;
        A_DEC_A:   c_res = ax - one;
        A_INC_B:   c_res = bx + one;
        A_DEC_B:   c_res = bx - one;
        A_CMP:     begin c_g = a > b; c_l = a < b; c_e = a == b; end
`ifdef ALU_MUL_EN
        A_MUL_INC, A_MUL_SHL: c_mul = 1'b1;
`endif
        default:   c_err = 1'b1;
      endcase
      c_cout = ((op_cmd == A_ADD) || (op_cmd == A_ADD_CIN)) && c_res[WIDTH];
    end else begin
      case (op_cmd)
        L_AND:    lres = a & b;
        L_NAND:   lres = ~(a & b);
        L_OR:     lres = a | b;
        L_NOR:    lres = ~(a | b);
        L_XOR:    lres = a ^ b;
        L_XNOR:   lres = ~(a ^ b);
        L_NOT_A:  lres = ~a;
        L_NOT_B:  lres = ~b;
        L_SHR1_A: lres = a >> 1;
        L_SHL1_A: lres = a << 1;
        L_SHR1_B: lres = b >> 1;
        L_SHL1_B: lres = b << 1;
        // Rotate through a doubled copy; out-of-range amount still drives the result.
        L_ROL:    begin rot = {a, a} << amt; lres = rot[2*WIDTH-1:WIDTH]; c_err = |(b >> SH); end
        L_ROR:    begin rot = {a, a} >> amt; lres = rot[WIDTH-1:0];       c_err = |(b >> SH); end
        default:  c_err = 1'b1;
      endcase
      c_res = {1'b0, lres};
    end
  end

`ifdef ALU_MUL_EN
  logic           mul_vld;
  logic [WIDTH:0] m_a, m_b, prod;
  assign prod = m_a * m_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0; cout <= 1'b0; oflow <= 1'b0; err <= 1'b0;
      g <= 1'b0; l <= 1'b0; e <= 1'b0;
`ifdef ALU_MUL_EN
      mul_vld <= 1'b0; m_a <= '0; m_b <= '0;
`endif
    end else if (ce) begin
`ifdef ALU_MUL_EN
      mul_vld <= op_valid && c_mul;
      if (op_valid && c_mul) begin
        m_a <= (op_cmd == A_MUL_INC) ? ax + one : {a, 1'b0};
        m_b <= (op_cmd == A_MUL_INC) ? bx + one : bx;
      end
      if (mul_vld) begin
        res <= prod; cout <= 1'b0; oflow <= 1'b0; err <= 1'b0;
        g <= 1'b0; l <= 1'b0; e <= 1'b0;
      end
`endif
      // A result issued this cycle overrides a multiply completing on the same edge.
      if (op_reject || op_timeout) begin
        res <= '0; cout <= 1'b0; oflow <= 1'b0; err <= 1'b1;
        g <= 1'b0; l <= 1'b0; e <= 1'b0;
      end else if (op_valid && !c_mul) begin
        res <= c_res; cout <= c_cout; oflow <= c_oflow; err <= c_err;
        g <= c_g; l <= c_l; e <= c_e;
      end
    end
  end

endmodule
